// File: rtl/usb2_ep_sched.sv
// Token-driven USB 2.0 endpoint scheduler: picks the target endpoint, answers RDY/NAK/STALL/NONE,
// relays commit/arm handshakes to the selected endpoint and keeps per-endpoint data toggles.
module usb2_ep_sched #(
    parameter int NUM_EP  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   phy_clk,
    input  logic                   reset_n,
    input  logic                   tok_valid,
    input  logic [3:0]             tok_pid,
    input  logic [3:0]             tok_ep,
    input  logic                   toggle_adv,
    input  logic                   buf_in_commit,
    input  logic [9:0]             buf_in_commit_len,
    output logic                   buf_in_commit_ack,
    output logic                   buf_in_ready,
    input  logic                   buf_out_arm,
    output logic                   buf_out_arm_ack,
    output logic                   buf_out_hasdata,
    output logic [9:0]             buf_out_len,
    output logic [NUM_EP-1:0]      ep_in_commit,
    input  logic [NUM_EP-1:0]      ep_in_commit_ack,
    input  logic [NUM_EP-1:0]      ep_in_ready,
    output logic [NUM_EP-1:0]      ep_out_arm,
    input  logic [NUM_EP-1:0]      ep_out_arm_ack,
    input  logic [NUM_EP-1:0]      ep_out_hasdata,
    input  logic [NUM_EP*10-1:0]   ep_out_len,
    input  logic [NUM_EP-1:0]      ep_halt,
    output logic [2:0]             ep_sel,
    output logic [1:0]             data_toggle,
    output logic                   resp_valid,
    output logic [1:0]             resp_code,
    output logic                   err_timeout,
    output logic                   err_overrun
);

    localparam logic [3:0] PID_OUT   = 4'hE;
    localparam logic [3:0] PID_IN    = 4'h6;
    localparam logic [3:0] PID_SETUP = 4'h2;

    localparam logic [1:0] RESP_RDY   = 2'd0;
    localparam logic [1:0] RESP_NAK   = 2'd1;
    localparam logic [1:0] RESP_STALL = 2'd2;
    localparam logic [1:0] RESP_NONE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_COMMIT,
        S_FWD_COMMIT,
        S_WAIT_ARM,
        S_FWD_ARM
    } state_t;

    state_t              state;
    logic                is_setup;
    logic                is_in;
    logic                ep_bad;
    logic [7:0]          toggles;
    logic [7:0]          toggles_next;
    logic [7:0]          cnt;
    logic [7:0]          cnt_next;
    logic                timed_out;
    logic                token_ok;
    logic                setup_clear;
    logic [7:0]          ready8;
    logic [7:0]          hasdata8;
    logic [7:0]          halt8;
    logic [7:0]          cack8;
    logic [7:0]          aack8;
    logic [79:0]         len8;
    logic [NUM_EP-1:0]   sel_hot;
    logic                unused_commit_len;

    // Endpoint vectors are widened to eight entries so any 3-bit ep_sel indexes safely.
    always_comb begin
        ready8   = '0;
        hasdata8 = '0;
        halt8    = '0;
        cack8    = '0;
        aack8    = '0;
        len8     = '0;
        sel_hot  = '0;
        ready8[NUM_EP-1:0]      = ep_in_ready;
        hasdata8[NUM_EP-1:0]    = ep_out_hasdata;
        halt8[NUM_EP-1:0]       = ep_halt;
        cack8[NUM_EP-1:0]       = ep_in_commit_ack;
        aack8[NUM_EP-1:0]       = ep_out_arm_ack;
        len8[NUM_EP*10-1:0]     = ep_out_len;
        for (int i = 0; i < NUM_EP; i++) begin
            sel_hot[i] = (ep_sel == 3'(i));
        end
    end

    assign token_ok    = (tok_pid == PID_OUT) || (tok_pid == PID_IN) || (tok_pid == PID_SETUP);
    assign setup_clear = (state == S_DECODE) && is_setup && !ep_bad && (ep_sel == 3'd0);
    assign cnt_next    = cnt + 8'd1;
    assign timed_out   = (cnt_next == 8'(TIMEOUT));

    // A SETUP clear on endpoint 0 overrides a same-cycle toggle advance.
    always_comb begin
        toggles_next = toggles;
        if (toggle_adv) begin
            toggles_next[ep_sel] = ~toggles[ep_sel];
        end
        if (setup_clear) begin
            toggles_next[0] = 1'b0;
        end
    end

    assign data_toggle       = {1'b0, toggles[ep_sel]};
    assign buf_in_ready      = ready8[ep_sel];
    assign buf_out_hasdata   = hasdata8[ep_sel];
    assign buf_out_len       = len8[int'(ep_sel)*10 +: 10];
    assign buf_in_commit_ack = (state == S_FWD_COMMIT) && cack8[ep_sel];
    assign buf_out_arm_ack   = (state == S_FWD_ARM) && aack8[ep_sel];

    // The committed length travels on the external buffer mux, not through this block.
    assign unused_commit_len = ^buf_in_commit_len;

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ep_sel       <= 3'd0;
            is_setup     <= 1'b0;
            is_in        <= 1'b0;
            ep_bad       <= 1'b0;
            toggles      <= '0;
            cnt          <= '0;
            resp_valid   <= 1'b0;
            resp_code    <= RESP_RDY;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            ep_in_commit <= '0;
            ep_out_arm   <= '0;
        end else begin
            resp_valid  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= tok_valid && (state != S_IDLE);
            toggles     <= toggles_next;
            case (state)
                S_IDLE: begin
                    if (tok_valid && token_ok) begin
                        is_setup <= (tok_pid == PID_SETUP);
                        is_in    <= (tok_pid == PID_IN);
                        ep_bad   <= (32'(tok_ep) >= NUM_EP);
                        ep_sel   <= tok_ep[2:0];
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    resp_valid <= 1'b1;
                    cnt        <= '0;
                    state      <= S_IDLE;
                    if (ep_bad) begin
                        resp_code <= RESP_NONE;
                    end else if (is_setup && (ep_sel != 3'd0)) begin
                        resp_code <= RESP_STALL;
                    end else if (is_setup) begin
                        resp_code <= ready8[0] ? RESP_RDY : RESP_NAK;
                        if (ready8[0]) state <= S_WAIT_COMMIT;
                    end else if (halt8[ep_sel]) begin
                        resp_code <= RESP_STALL;
                    end else if (is_in) begin
                        resp_code <= hasdata8[ep_sel] ? RESP_RDY : RESP_NAK;
                        if (hasdata8[ep_sel]) state <= S_WAIT_ARM;
                    end else begin
                        resp_code <= ready8[ep_sel] ? RESP_RDY : RESP_NAK;
                        if (ready8[ep_sel]) state <= S_WAIT_COMMIT;
                    end
                end
                S_WAIT_COMMIT: begin
                    if (buf_in_commit) begin
                        ep_in_commit <= sel_hot;
                        cnt          <= '0;
                        state        <= S_FWD_COMMIT;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                S_FWD_COMMIT: begin
                    if (cack8[ep_sel] || timed_out) begin
                        err_timeout  <= !cack8[ep_sel];
                        ep_in_commit <= '0;
                        state        <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                S_WAIT_ARM: begin
                    if (buf_out_arm) begin
                        ep_out_arm <= sel_hot;
                        cnt        <= '0;
                        state      <= S_FWD_ARM;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                S_FWD_ARM: begin
                    if (aack8[ep_sel] || timed_out) begin
                        err_timeout <= !aack8[ep_sel];
                        ep_out_arm  <= '0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
